// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver for the parking front panel.
// Scans one digit per clock from a frame-coherent snapshot of two pages.
module seg_scan_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int SEL_WIDTH    = 5,
    parameter int SEL_OFFSET   = 1,
    parameter int BLINK_FRAMES = 62
) (
    input  logic                      clk_500Hz,
    input  logic                      reset,
    input  logic                      page_sel,
    input  logic [4*NUM_DIGITS-1:0]   page0_bcd,
    input  logic [4*NUM_DIGITS-1:0]   page1_bcd,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic                      lzb_en,
    output logic [SEL_WIDTH-1:0]      SEG_SEL,
    output logic [7:0]                SEG_DATA,
    output logic                      frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] snap_codes;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_lzb;

    logic [3:0]              digit_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_run;
    logic [SEL_WIDTH-1:0]    sel_next;
    logic [7:0]              data_next;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hF: g = 7'h00;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // Unpack the snapshot and find the run of zero codes from the top digit down.
    always_comb begin
        logic nz_seen;
        nz_seen = 1'b0;
        zero_run = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_code[i] = snap_codes[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run[i] = ~nz_seen & (digit_code[i] == 4'h0);
            nz_seen = nz_seen | (digit_code[i] != 4'h0);
        end
    end

    // Render the current digit: blank/blink-off beats suppression beats glyph.
    always_comb begin
        logic off;
        logic sup;
        off = snap_blank[idx] | (snap_blink[idx] & blink_phase);
        sup = snap_lzb & zero_run[idx] & (idx != '0);
        sel_next = SEL_WIDTH'(1) << (SEL_OFFSET + int'(idx));
        if (off) begin
            data_next = 8'h00;
        end else if (sup) begin
            data_next = {snap_dp[idx], 7'h00};
        end else begin
            data_next = {snap_dp[idx], glyph(digit_code[idx])};
        end
    end

    // Scan, register pins, and capture inputs plus blink timing at frame end.
    always_ff @(posedge clk_500Hz or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_codes  <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            snap_dp     <= '0;
            snap_lzb    <= 1'b0;
            SEG_SEL     <= '0;
            SEG_DATA    <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            SEG_SEL     <= sel_next;
            SEG_DATA    <= data_next;
            frame_start <= (idx == '0);
            if (idx == IDX_LAST) begin
                idx        <= '0;
                snap_codes <= page_sel ? page1_bcd : page0_bcd;
                snap_blank <= blank_mask;
                snap_blink <= blink_mask;
                snap_dp    <= dp_mask;
                snap_lzb   <= lzb_en;
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: scan order, glyphs, blanking,
// leading-zero suppression, blink, page switching and reset behaviour.
module tb_seg_scan_display;

    logic        clk_500Hz = 1'b0;
    logic        reset = 1'b0;
    logic        page_sel = 1'b0;
    logic [15:0] page0_bcd = '0;
    logic [15:0] page1_bcd = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic        lzb_en = 1'b0;
    logic [4:0]  SEG_SEL;
    logic [7:0]  SEG_DATA;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    seg_scan_display #(
        .NUM_DIGITS(4),
        .SEL_WIDTH(5),
        .SEL_OFFSET(1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk_500Hz(clk_500Hz),
        .reset(reset),
        .page_sel(page_sel),
        .page0_bcd(page0_bcd),
        .page1_bcd(page1_bcd),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .dp_mask(dp_mask),
        .lzb_en(lzb_en),
        .SEG_SEL(SEG_SEL),
        .SEG_DATA(SEG_DATA),
        .frame_start(frame_start)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    task automatic tick;
        @(posedge clk_500Hz);
        #1;
    endtask

    // Hold reset for two edges; release just after an edge so the next
    // edge is edge 1 (digit 0 from the zero snapshot).
    task automatic restart;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic set_inputs(input logic [15:0] p0, input logic lz,
                              input logic [3:0] dp, input logic [3:0] bl);
        page_sel = 1'b0;
        page0_bcd = p0;
        lzb_en = lz;
        dp_mask = dp;
        blank_mask = bl;
        blink_mask = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        page0_bcd = 16'h1234;
        tick();
        checks++;
        if (SEG_SEL !== 5'b0 || SEG_DATA !== 8'h00 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_state sel=%b data=%h fs=%b want 00000/00/0",
                     SEG_SEL, SEG_DATA, frame_start);
        end
    endtask

    task automatic test_scan;
        logic [7:0] exp_d [9] = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h66,
                                  8'h4F, 8'h5B, 8'h06, 8'h66};
        set_inputs(16'h1234, 1'b0, 4'h0, 4'h0);
        restart();
        for (int e = 1; e <= 9; e++) begin
            logic [4:0] exp_s;
            logic exp_f;
            tick();
            exp_s = 5'b00010 << ((e - 1) % 4);
            exp_f = ((e - 1) % 4) == 0;
            checks++;
            if (SEG_SEL !== exp_s || SEG_DATA !== exp_d[e-1]) begin
                failures++;
                $display("FAIL scan edge%0d sel=%b data=%h want %b/%h",
                         e, SEG_SEL, SEG_DATA, exp_s, exp_d[e-1]);
            end
            checks++;
            if (frame_start !== exp_f) begin
                failures++;
                $display("FAIL frame_start edge%0d got=%b want=%b",
                         e, frame_start, exp_f);
            end
        end
    endtask

    task automatic test_mid_reset;
        set_inputs(16'h1234, 1'b0, 4'h0, 4'h0);
        restart();
        repeat (6) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (SEG_SEL !== 5'b0 || SEG_DATA !== 8'h00 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL async_clear sel=%b data=%h fs=%b want 00000/00/0",
                     SEG_SEL, SEG_DATA, frame_start);
        end
        repeat (3) tick();
        checks++;
        if (SEG_SEL !== 5'b0 || SEG_DATA !== 8'h00) begin
            failures++;
            $display("FAIL held_reset sel=%b data=%h want 00000/00",
                     SEG_SEL, SEG_DATA);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (SEG_SEL !== 5'b00010 || SEG_DATA !== 8'h3F || frame_start !== 1'b1) begin
            failures++;
            $display("FAIL restart sel=%b data=%h fs=%b want 00010/3f/1",
                     SEG_SEL, SEG_DATA, frame_start);
        end
    endtask

    // Each vector: page0, lzb, dp, blank, expected {d3,d2,d1,d0}.
    task automatic test_render;
        logic [15:0] pv [9] = '{16'h0070, 16'h0000, 16'h0005, 16'h0070,
                                16'h0807, 16'hF0A5, 16'h6789, 16'hBCDE,
                                16'hF0A5};
        logic        lv [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0]  dv [9] = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'hF};
        logic [3:0]  bv [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                4'h0, 4'h0, 4'h0, 4'h2};
        logic [31:0] ev [9] = '{32'h0000_073F, 32'h0000_003F,
                                32'h0080_006D, 32'h3F3F_073F,
                                32'h007F_3F07, 32'h003F_406D,
                                32'h7D07_7F6F, 32'h4040_4040,
                                32'h80BF_00ED};
        for (int v = 0; v < 9; v++) begin
            set_inputs(pv[v], lv[v], dv[v], bv[v]);
            restart();
            repeat (4) tick();
            for (int d = 0; d < 4; d++) begin
                logic [7:0] exp_d;
                logic [31:0] row;
                tick();
                row = ev[v];
                exp_d = row[8*d +: 8];
                checks++;
                if (SEG_SEL !== (5'b00010 << d) || SEG_DATA !== exp_d) begin
                    failures++;
                    $display("FAIL render v%0d digit%0d sel=%b data=%h want %b/%h",
                             v, d, SEG_SEL, SEG_DATA, 5'b00010 << d, exp_d);
                end
            end
        end
    endtask

    task automatic test_page_sel;
        logic [7:0] exp_d [7] = '{8'h4F, 8'h5B, 8'h06, 8'h6F,
                                  8'h6F, 8'h6F, 8'h6F};
        set_inputs(16'h1234, 1'b0, 4'h0, 4'h0);
        page1_bcd = 16'h9999;
        restart();
        repeat (5) tick();
        page_sel = 1'b1;
        for (int e = 6; e <= 12; e++) begin
            tick();
            checks++;
            if (SEG_DATA !== exp_d[e-6]) begin
                failures++;
                $display("FAIL page_sel edge%0d data=%h want %h",
                         e, SEG_DATA, exp_d[e-6]);
            end
        end
        page_sel = 1'b0;
    endtask

    // Phase flips on every second frame-end edge: 8, 16, 24.
    task automatic test_blink;
        logic [7:0] exp_d [6] = '{8'h7F, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h00};
        set_inputs(16'h0008, 1'b0, 4'h0, 4'h0);
        blink_mask = 4'b0001;
        restart();
        for (int e = 1; e <= 28; e++) begin
            tick();
            if (e >= 5 && (e % 4) == 1) begin
                checks++;
                if (SEG_DATA !== exp_d[(e-5)/4]) begin
                    failures++;
                    $display("FAIL blink edge%0d data=%h want %h",
                             e, SEG_DATA, exp_d[(e-5)/4]);
                end
            end
            if (e >= 6 && (e % 4) == 2) begin
                checks++;
                if (SEG_DATA !== 8'h3F) begin
                    failures++;
                    $display("FAIL blink_other edge%0d data=%h want 3f",
                             e, SEG_DATA);
                end
            end
        end
        blink_mask = '0;
    endtask

    task automatic test_blank;
        set_inputs(16'h0008, 1'b0, 4'h1, 4'b0001);
        restart();
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e >= 5 && (e % 4) == 1) begin
                checks++;
                if (SEG_DATA !== 8'h00) begin
                    failures++;
                    $display("FAIL blank edge%0d data=%h want 00", e, SEG_DATA);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mid_reset();
        test_render();
        test_page_sel();
        test_blink();
        test_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
